// File: rtl/enc_loop_sequencer_pkg.sv
// Shared definitions for the encode loop sequencer: FSM state encoding,
// command type constants and a small sizing helper.
package enc_loop_sequencer_pkg;

  // One-hot sequencer states
  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_DATA    = 5'b00010,
    S_PARITY  = 5'b00100,
    S_LOOPEND = 5'b01000,
    S_DONE    = 5'b10000
  } seqState_t;

  localparam logic [1:0] CMD_ENCODE      = 2'b01;
  localparam logic [1:0] CMD_PARITY_ONLY = 2'b10;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/enc_beat_counter.sv
// Beat counter with synchronous clear, count enable and a terminal-count
// compare. The count itself stays internal; only the compare leaves.
module enc_beat_counter #(
  parameter int Width = 9
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iClear,
  input  logic             iEnable,
  input  logic [Width-1:0] iTerminal,
  output logic             oAtTerminal
);

  logic [Width-1:0] count;

  // Clear has priority so a terminal beat that also changes state restarts at 0
  always_ff @(posedge iClock) begin
    if (iReset || iClear) count <= '0;
    else if (iEnable)     count <= count + Width'(1);
  end

  assign oAtTerminal = (count == iTerminal);

endmodule

// File: rtl/enc_loop_sequencer.sv
// Encode loop sequencer: steers the source stream and then the encoder
// parity stream onto the converter-side stream, twice per command, and
// reports completion. Datapath is pure muxing; no beat is stored.
module enc_loop_sequencer
  import enc_loop_sequencer_pkg::*;
#(
  parameter int DataWidth   = 16,
  parameter int DataBeats   = 256,
  parameter int ParityBeats = 14
) (
  input  logic                 iClock,
  input  logic                 iReset,
  input  logic                 iCmdValid,
  output logic                 oCmdReady,
  input  logic [1:0]           iCmdType,
  output logic                 oCmdDone,
  output logic                 oCmdError,
  input  logic                 iSrcValid,
  input  logic [DataWidth-1:0] iSrcData,
  output logic                 oSrcReady,
  input  logic                 iParityValid,
  input  logic [DataWidth-1:0] iParityData,
  output logic                 oParityReady,
  output logic                 oConvValid,
  output logic [DataWidth-1:0] oConvData,
  output logic                 oConvDataLast,
  output logic                 oConvParityLast,
  input  logic                 iConvReady,
  output logic [1:0]           oCmdType,
  output logic                 oCurLoopCount
);

  localparam int CntWidth = $clog2(maxInt(DataBeats, ParityBeats) + 1);
  localparam logic [CntWidth-1:0] DataTerm   = CntWidth'(DataBeats - 1);
  localparam logic [CntWidth-1:0] ParityTerm = CntWidth'(ParityBeats - 1);

  seqState_t           state, nextState;
  logic [1:0]          cmdType;
  logic                loopCount;
  logic                errFlag;
  logic                convXfer;
  logic                cntClear;
  logic                atTerm;
  logic [CntWidth-1:0] terminal;

  // State register
  always_ff @(posedge iClock) begin
    if (iReset) state <= S_IDLE;
    else        state <= nextState;
  end

  // Next state and stream steering; all handshakes held low while in reset
  always_comb begin
    nextState       = state;
    oCmdReady       = 1'b0;
    oSrcReady       = 1'b0;
    oParityReady    = 1'b0;
    oConvValid      = 1'b0;
    oConvData       = '0;
    oConvDataLast   = 1'b0;
    oConvParityLast = 1'b0;
    oCmdDone        = 1'b0;
    oCmdError       = 1'b0;
    terminal        = DataTerm;
    if (!iReset) begin
      unique case (state)
        S_IDLE: begin
          oCmdReady = 1'b1;
          if (iCmdValid) begin
            case (iCmdType)
              CMD_ENCODE:      nextState = S_DATA;
              CMD_PARITY_ONLY: nextState = S_PARITY;
              default:         nextState = S_DONE;
            endcase
          end
        end
        S_DATA: begin
          terminal      = DataTerm;
          oConvValid    = iSrcValid;
          oConvData     = iSrcData;
          oSrcReady     = iConvReady;
          oConvDataLast = iSrcValid & atTerm;
          if (iSrcValid && iConvReady && atTerm) nextState = S_PARITY;
        end
        S_PARITY: begin
          terminal        = ParityTerm;
          oConvValid      = iParityValid;
          oConvData       = iParityData;
          oParityReady    = iConvReady;
          oConvParityLast = iParityValid & atTerm;
          if (iParityValid && iConvReady && atTerm) nextState = S_LOOPEND;
        end
        S_LOOPEND: begin
          if (!loopCount) nextState = (cmdType == CMD_PARITY_ONLY) ? S_PARITY : S_DATA;
          else            nextState = S_DONE;
        end
        S_DONE: begin
          oCmdDone  = 1'b1;
          oCmdError = errFlag;
          nextState = S_IDLE;
        end
        default: nextState = S_IDLE;
      endcase
    end
  end

  assign convXfer = oConvValid & iConvReady;
  assign cntClear = (nextState != state);

  enc_beat_counter #(.Width(CntWidth)) uBeatCnt (
    .iClock      (iClock),
    .iReset      (iReset),
    .iClear      (cntClear),
    .iEnable     (convXfer),
    .iTerminal   (terminal),
    .oAtTerminal (atTerm)
  );

  // Command bookkeeping: latched type, loop index and error flag
  always_ff @(posedge iClock) begin
    if (iReset) begin
      cmdType   <= 2'b00;
      loopCount <= 1'b0;
      errFlag   <= 1'b0;
    end else begin
      if (state == S_IDLE && iCmdValid) begin
        cmdType <= iCmdType;
        errFlag <= !(iCmdType == CMD_ENCODE || iCmdType == CMD_PARITY_ONLY);
      end
      if (state == S_LOOPEND && !loopCount) loopCount <= 1'b1;
      if (state == S_DONE) begin
        loopCount <= 1'b0;
        errFlag   <= 1'b0;
      end
    end
  end

  assign oCmdType      = cmdType;
  assign oCurLoopCount = loopCount;

endmodule

// File: tb/tb_enc_loop_sequencer.sv
// Scoreboard bench for enc_loop_sequencer with DataBeats=4, ParityBeats=2.
module tb_enc_loop_sequencer;
  import enc_loop_sequencer_pkg::*;

  localparam int DW = 16;
  localparam int DB = 4;
  localparam int PB = 2;

  logic          iClock = 1'b0;
  logic          iReset = 1'b1;
  logic          iCmdValid = 1'b0;
  logic          oCmdReady;
  logic [1:0]    iCmdType = 2'b00;
  logic          oCmdDone, oCmdError;
  logic          iSrcValid = 1'b0;
  logic [DW-1:0] iSrcData = 16'h1000;
  logic          oSrcReady;
  logic          iParityValid = 1'b0;
  logic [DW-1:0] iParityData = 16'hA000;
  logic          oParityReady;
  logic          oConvValid;
  logic [DW-1:0] oConvData;
  logic          oConvDataLast, oConvParityLast;
  logic          iConvReady = 1'b0;
  logic [1:0]    oCmdType;
  logic          oCurLoopCount;

  always #5 iClock = ~iClock;

  enc_loop_sequencer #(.DataWidth(DW), .DataBeats(DB), .ParityBeats(PB)) dut (
    .iClock(iClock), .iReset(iReset),
    .iCmdValid(iCmdValid), .oCmdReady(oCmdReady), .iCmdType(iCmdType),
    .oCmdDone(oCmdDone), .oCmdError(oCmdError),
    .iSrcValid(iSrcValid), .iSrcData(iSrcData), .oSrcReady(oSrcReady),
    .iParityValid(iParityValid), .iParityData(iParityData), .oParityReady(oParityReady),
    .oConvValid(oConvValid), .oConvData(oConvData), .oConvDataLast(oConvDataLast),
    .oConvParityLast(oConvParityLast), .iConvReady(iConvReady),
    .oCmdType(oCmdType), .oCurLoopCount(oCurLoopCount)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          dLast;
    logic          pLast;
    logic          loopCnt;
  } beat_t;

  beat_t      expQ[$];
  logic       doneQ[$];
  int         errors = 0;
  int         checks = 0;
  int         xferCount = 0;
  int         srcIdx = 0, parIdx = 0;
  int         expSrc = 0, expPar = 0;
  int         cyc = 0, lastPCyc = -1;
  bit         srcXfer = 0, parXfer = 0, gapMode = 0;
  logic [1:0] expType = 2'b00;
  beat_t      monBeat;
  logic       monErr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  // Expected converter beats for one command, truncated after 'limit' beats
  task automatic pushBeats(input bit parityOnly, input int limit);
    int    n = 0;
    beat_t b;
    for (int l = 0; l < 2; l++) begin
      if (!parityOnly) begin
        for (int k = 0; k < DB; k++) begin
          if (n < limit) begin
            b.data = DW'(32'h1000 + expSrc); b.dLast = (k == DB-1); b.pLast = 1'b0; b.loopCnt = 1'(l);
            expQ.push_back(b); expSrc++; n++;
          end
        end
      end
      for (int k = 0; k < PB; k++) begin
        if (n < limit) begin
          b.data = DW'(32'hA000 + expPar); b.dLast = 1'b0; b.pLast = (k == PB-1); b.loopCnt = 1'(l);
          expQ.push_back(b); expPar++; n++;
        end
      end
    end
  endtask

  task automatic issue(input logic [1:0] t);
    expType   = t;
    iCmdType  = t;
    iCmdValid = 1'b1;
    @(negedge iClock);
    check("cmd ready in idle", oCmdReady, 1);
    tick();
    iCmdValid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((expQ.size() != 0 || doneQ.size() != 0) && n < 1000) begin
      tick();
      n++;
    end
    check({"drain ", name}, (n < 1000), 1);
    repeat (6) tick();
  endtask

  task automatic waitXfers(input int target);
    int n = 0;
    while (xferCount < target && n < 500) begin
      tick();
      n++;
    end
    check("wait for beats", (xferCount >= target), 1);
  endtask

  // Stream sources: data advances only on an accepted beat
  always @(posedge iClock) begin
    #1;
    if (srcXfer) srcIdx++;
    if (parXfer) parIdx++;
    iSrcData    = DW'(32'h1000 + srcIdx);
    iParityData = DW'(32'hA000 + parIdx);
    if (gapMode) begin
      iSrcValid    = ($urandom_range(0, 3) != 0);
      iParityValid = ($urandom_range(0, 3) != 0);
      iConvReady   = ($urandom_range(0, 2) != 0);
    end else begin
      iSrcValid    = 1'b1;
      iParityValid = 1'b1;
      iConvReady   = 1'b1;
    end
  end

  // Monitor: compare every converter beat and completion pulse to the queues
  always @(negedge iClock) begin
    cyc++;
    srcXfer = iSrcValid & oSrcReady;
    parXfer = iParityValid & oParityReady;
    if (oConvValid && iConvReady) begin
      if (expQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected beat: got %0h expected none", oConvData);
      end else begin
        monBeat = expQ.pop_front();
        check("beat data", oConvData, monBeat.data);
        check("data last", oConvDataLast, monBeat.dLast);
        check("parity last", oConvParityLast, monBeat.pLast);
        check("loop count", oCurLoopCount, monBeat.loopCnt);
        check("cmd type", oCmdType, expType);
      end
      if (oConvParityLast && oCurLoopCount) lastPCyc = cyc;
      xferCount++;
    end
    if (oCmdDone) begin
      if (doneQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected done: got 1 expected 0");
      end else begin
        monErr = doneQ.pop_front();
        check("cmd error", oCmdError, monErr);
      end
      if (lastPCyc >= 0) check("done latency", cyc - lastPCyc, 2);
      lastPCyc = -1;
    end else if (oCmdError) begin
      checks++; errors++;
      $display("FAIL error without done: got 1 expected 0");
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    repeat (3) tick();
    @(negedge iClock);
    check("reset ready", oCmdReady, 0);
    check("reset conv valid", oConvValid, 0);
    check("reset src ready", oSrcReady, 0);
    check("reset done", oCmdDone, 0);
    check("reset loop", oCurLoopCount, 0);
    check("reset type", oCmdType, 0);
    tick();
    iReset = 1'b0;
    @(negedge iClock);
    check("idle ready", oCmdReady, 1);
    tick();

    // ENCODE, always ready: 12 beats, two loops
    pushBeats(1'b0, 99); doneQ.push_back(1'b0);
    issue(CMD_ENCODE);
    waitDrain("encode");

    // PARITY_ONLY: 4 parity beats, source untouched
    pushBeats(1'b1, 99); doneQ.push_back(1'b0);
    issue(CMD_PARITY_ONLY);
    waitDrain("parity only");
    check("no source reads", srcIdx, expSrc);
    check("parity count", parIdx, expPar);

    // Illegal type: immediate done with error
    doneQ.push_back(1'b1);
    issue(2'b11);
    @(negedge iClock);
    check("err done pulse", oCmdDone, 1);
    check("err error pulse", oCmdError, 1);
    check("err type held", oCmdType, 3);
    tick();
    waitDrain("illegal");

    // ENCODE with random stalls on both sides
    gapMode = 1'b1;
    pushBeats(1'b0, 99); doneQ.push_back(1'b0);
    issue(CMD_ENCODE);
    waitDrain("gapped encode");
    gapMode = 1'b0;
    check("gapped src count", srcIdx, expSrc);
    check("gapped par count", parIdx, expPar);
    repeat (2) tick();

    // Reset at data beat 2 of the second loop
    base = xferCount;
    pushBeats(1'b0, 8);
    issue(CMD_ENCODE);
    waitXfers(base + 8);
    iReset = 1'b1;
    @(negedge iClock);
    check("rst conv valid", oConvValid, 0);
    check("rst src ready", oSrcReady, 0);
    check("rst parity ready", oParityReady, 0);
    check("rst cmd ready", oCmdReady, 0);
    tick();
    iReset = 1'b0;
    @(negedge iClock);
    check("post rst ready", oCmdReady, 1);
    check("post rst loop", oCurLoopCount, 0);
    check("post rst type", oCmdType, 0);
    check("aborted beats", expQ.size(), 0);
    tick();
    pushBeats(1'b0, 99); doneQ.push_back(1'b0);
    issue(CMD_ENCODE);
    waitDrain("post reset encode");

    // Command pulsed during Parity is ignored
    base = xferCount;
    pushBeats(1'b0, 99); doneQ.push_back(1'b0);
    issue(CMD_ENCODE);
    waitXfers(base + 4);
    iCmdType  = 2'b11;
    iCmdValid = 1'b1;
    @(negedge iClock);
    check("busy ready", oCmdReady, 0);
    tick();
    iCmdValid = 1'b0;
    iCmdType  = CMD_ENCODE;
    waitDrain("ignored cmd");
    check("final src count", srcIdx, expSrc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
